rb_writeback_regfile: RTL
=========================

// Module: rb_writeback_regfile
// PURPOSE
//  Register-writeback (RB) stage consumer: takes the registered outputs of the M->RB
//  pipeline register and selects the writeback value. It commits that value into the
//  architectural integer register file and serves the two decode-stage read ports.
//  It also keeps a retired-instruction counter. Sits at the tail of the 5-stage core,
//  closing the loop back to decode.
// PARAMETERS
//  XLEN   32  datapath / register width
//  NREG   32  number of architectural registers (x0..x31); address width = $clog2(NREG)
//  CNT_W  64  width of retired-instruction counter
// PORTS
//  clk            in   1     rising-edge clock
//  rst            in   1     synchronous, active-high reset
//  rb_valid       in   1     1 = real instruction in RB this cycle (0 = bubble)
//  PMAItoReg_RB   in   2     writeback select: 00 ALU, 01 MEM, 10 IMM, 11 PC+4
//  rd_wen_RB      in   1     destination write enable
//  imm_RB         in   XLEN  immediate (LUI path)
//  mem_rdata_RB   in   XLEN  load data, already extended
//  alu_result_RB  in   XLEN  ALU result
//  PC_RB          in   XLEN  PC of instruction in RB
//  rd_waddr_RB    in   5     destination register index
//  rs1_raddr      in   5     decode read port 1 address
//  rs2_raddr      in   5     decode read port 2 address
//  rs1_rdata      out  XLEN  read port 1 data (combinational)
//  rs2_rdata      out  XLEN  read port 2 data (combinational)
//  wb_data        out  XLEN  selected writeback value (combinational, for EX forwarding)
//  wb_commit      out  1     rb_valid & rd_wen_RB & (rd_waddr_RB != 0) & ~rst
//  retire_cnt     out  CNT_W retired-instruction count (registered)
// BEHAVIOUR
//  - Writeback mux: 00 -> alu_result_RB; 01 -> mem_rdata_RB; 10 -> imm_RB;
//    11 -> PC_RB + 4 (mod 2^XLEN; 32'hFFFFFFFC wraps to 0).
//  - Write: on posedge clk, regs[rd_waddr_RB] <= wb_data when wb_commit. Single write
//    port; one write per cycle; visible in the array the next cycle.
//  - x0: never written (wb_commit forced 0 for rd=0); reads of address 0 return 0.
//  - Reads: combinational from the array, with an optional bypass (see CONFIGURATION).
//  - retire_cnt: +1 on each posedge with rb_valid=1 and rst=0, whether or not rd is
//    written (stores/branches count). Wraps from all-ones to 0 without saturating.
//  - Bubbles (rb_valid=0): no write, no count; all rd_wen/PMAItoReg values are ignored.
//  - Reset (rst=1 at posedge): all registers x1..x31 <- 0, retire_cnt <- 0. Reset wins
//    over a simultaneous write or retire. Reset asserted mid-stream discards the RB
//    instruction. After reset, rs1_rdata=rs2_rdata=0 for every address;
//    wb_data follows its inputs; wb_commit=0 while rst=1.
//  - No stall input: RB always drains; upstream holds RB inputs stable for one cycle.
// CONFIGURATION
//  RB_BYPASS_EN defined: write-through read. If wb_commit=1 and rsN_raddr==rd_waddr_RB
//    (nonzero), rsN_rdata = wb_data in the same cycle. Decode sees the new value without
//    a stall; rd=0 is never bypassed.
//  RB_BYPASS_EN undefined: reads return the array contents only. Decode receives the
//    old value in the write cycle and the hazard unit inserts one stall for an RB->ID
//    RAW dependency.
// TESTING
//  1 Reset: rst=1 for 2 cycles, then read all 32 addresses -> every rsN_rdata=0,
//    retire_cnt=0.
//  2 Mux: rd=5, wen=1, valid=1 with sel 00/01/10/11; alu=0x11, mem=0x22, imm=0x33000,
//    PC=0x100 -> x5 reads 0x11, 0x22, 0x33000, 0x104 on successive cycles; PC=0xFFFFFFFC,
//    sel 11 -> 0x0.
//  3 x0/bubble: write 0xDEAD to rd=0 (valid=1), then to rd=7 with valid=0 -> x0=0,
//    x7 unchanged, wb_commit=0 both cycles, retire_cnt +1 only.
//  4 Same-cycle read: write 0xCAFE to x9 while rs1_raddr=9 -> rs1_rdata=0xCAFE that
//    cycle with RB_BYPASS_EN, old value without it; 0xCAFE next cycle in both builds.
//  5 Reset mid-stream: valid write 0x1234 to x3 with rst=1 in the same cycle -> x3=0,
//    retire_cnt=0.
//  6 Counter: 10 valid + 5 bubble cycles -> retire_cnt=10; force cnt to all-ones,
//    1 valid -> 0.

Source files
------------

// File: rtl/rb_writeback_regfile.sv
// rb_writeback_regfile: writeback stage of the 5-stage core.
//
// It selects the writeback value from the M->RB pipeline register outputs.
// It commits that value into the integer register file, x0..x(NREG-1).
// It serves the two decode read ports.
// It keeps the retired-instruction counter.
//
// Optional feature macro: RB_BYPASS_EN
//   defined   : write-through read. A committing write to rsN_raddr is seen by decode
//               in the same cycle.
//   undefined : reads return array contents only. The hazard unit stalls on RB->ID RAW.
module rb_writeback_regfile #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int CNT_W = 64,
    localparam int AW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rb_valid,
    input  logic [1:0]       PMAItoReg_RB,
    input  logic             rd_wen_RB,
    input  logic [XLEN-1:0]  imm_RB,
    input  logic [XLEN-1:0]  mem_rdata_RB,
    input  logic [XLEN-1:0]  alu_result_RB,
    input  logic [XLEN-1:0]  PC_RB,
    input  logic [AW-1:0]    rd_waddr_RB,
    input  logic [AW-1:0]    rs1_raddr,
    input  logic [AW-1:0]    rs2_raddr,
    output logic [XLEN-1:0]  rs1_rdata,
    output logic [XLEN-1:0]  rs2_rdata,
    output logic [XLEN-1:0]  wb_data,
    output logic             wb_commit,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_IMM = 2'b10;

    logic [XLEN-1:0]  regs_q [NREG];
    logic [XLEN-1:0]  regs_d [NREG];
    logic [CNT_W-1:0] retire_cnt_q;
    logic [CNT_W-1:0] retire_cnt_d;

    // Writeback value select. PC+4 wraps modulo 2^XLEN.
    always_comb begin
        unique case (PMAItoReg_RB)
            SEL_ALU: wb_data = alu_result_RB;
            SEL_MEM: wb_data = mem_rdata_RB;
            SEL_IMM: wb_data = imm_RB;
            default: wb_data = PC_RB + XLEN'(4);
        endcase
    end

    // A write commits only for a real instruction targeting a nonzero rd outside reset.
    always_comb begin
        wb_commit = rb_valid & rd_wen_RB & (rd_waddr_RB != '0) & ~rst;
    end

    // Next-state of the register array and the retire counter.
    always_comb begin
        regs_d = regs_q;
        if (wb_commit) begin
            regs_d[rd_waddr_RB] = wb_data;
        end
        regs_d[0] = '0;

        retire_cnt_d = retire_cnt_q;
        if (rb_valid) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end
    end

    // State registers. Reset wins over a same-cycle write or retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q       <= '{default: '0};
            retire_cnt_q <= '0;
        end else begin
            regs_q       <= regs_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Decode read ports. Address 0 always reads zero.
    // The bypass path never fires for rd=0, because wb_commit already excludes rd=0.
    always_comb begin
        rs1_rdata = (rs1_raddr == '0) ? '0 : regs_q[rs1_raddr];
        rs2_rdata = (rs2_raddr == '0) ? '0 : regs_q[rs2_raddr];
`ifdef RB_BYPASS_EN
        if (wb_commit && (rs1_raddr == rd_waddr_RB)) begin
            rs1_rdata = wb_data;
        end
        if (wb_commit && (rs2_raddr == rd_waddr_RB)) begin
            rs2_rdata = wb_data;
        end
`else
`endif
    end

    assign retire_cnt = retire_cnt_q;

endmodule
